encrypt_function_4: RTL and testbench

- Transmit-side counterpart of the function-4 decryptor.
- Takes 60-bit plaintext words over a valid/ready handshake and draws an 11-bit key from an internal LFSR.
- Emits 78-bit frames {rand[10:0], y[60:0], seq[5:0]}, with y = ({plaintext,1'b0} + b) mod 2^61.
- Sits between the plaintext source and the channel. Two-stage pipeline with backpressure, one word per cycle.

---
 rtl/encrypt_function_4.sv | 102 ++++++++++
 tb/tb_encrypt_function_4.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_function_4.sv
// Function-4 encryptor: LFSR-keyed frame builder, 2-stage pipeline, one word/cycle.
// Output appears two edges after acceptance; stalls upstream once both stages are full.
module encrypt_function_4 #(
  parameter logic [10:0] SEED = 11'h5A5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        seed_load,
  input  logic [10:0] seed_val,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [59:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [77:0] outEnc
);

  // An all-zero state would lock the LFSR, so zero seeds are forced to 1.
  localparam logic [10:0] SEED_FIX = (SEED == 11'h000) ? 11'h001 : SEED;

  logic [10:0] lfsr_q, lfsr_d;
  logic [5:0]  seq_q, seq_d;
  logic        s1_valid_q, s1_valid_d;
  logic [59:0] s1_data_q, s1_data_d;
  logic [10:0] s1_rand_q, s1_rand_d;
  logic [5:0]  s1_seq_q, s1_seq_d;
  logic        s2_valid_q, s2_valid_d;
  logic [77:0] out_enc_q, out_enc_d;

  logic        s1_move;
  logic        accept;
  logic [60:0] y;

  function automatic logic [59:0] key_mask(input logic [10:0] r);
    return {r[4:0], ~r, r, ~r, ~r, r};
  endfunction

  assign s1_move   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s1_move;
  assign accept    = in_valid && in_ready;
  assign y         = {s1_data_q, 1'b0} + {1'b0, key_mask(s1_rand_q)};
  assign out_valid = s2_valid_q;
  assign outEnc    = out_enc_q;

  always_comb begin
    lfsr_d     = lfsr_q;
    seq_d      = seq_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_rand_d  = s1_rand_q;
    s1_seq_d   = s1_seq_q;
    s2_valid_d = s2_valid_q;
    out_enc_d  = out_enc_q;

    // A seed load wins over the advance; the word accepted now still sees lfsr_q.
    if (seed_load) begin
      lfsr_d = (seed_val == 11'h000) ? 11'h001 : seed_val;
    end else if (accept) begin
      lfsr_d = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_rand_d  = lfsr_q;
      s1_seq_d   = seq_q;
      seq_d      = seq_q + 6'd1;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    if (s1_move) begin
      s2_valid_d = 1'b1;
      out_enc_d  = {s1_rand_q, y, s1_seq_q};
    end else if (s2_valid_q && out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      lfsr_q     <= SEED_FIX;
      seq_q      <= 6'd0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= 60'd0;
      s1_rand_q  <= 11'd0;
      s1_seq_q   <= 6'd0;
      s2_valid_q <= 1'b0;
      out_enc_q  <= 78'd0;
    end else begin
      lfsr_q     <= lfsr_d;
      seq_q      <= seq_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_rand_q  <= s1_rand_d;
      s1_seq_q   <= s1_seq_d;
      s2_valid_q <= s2_valid_d;
      out_enc_q  <= out_enc_d;
    end
  end

endmodule

// File: tb/tb_encrypt_function_4.sv
// Scoreboard bench for encrypt_function_4: directed vectors, streaming, stalls, seed load, reset.
module tb_encrypt_function_4;

  localparam logic [10:0] SEED = 11'h7FF;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        seed_load = 1'b0;
  logic [10:0] seed_val = 11'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [59:0] in_data = 60'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [77:0] outEnc;

  encrypt_function_4 #(.SEED(SEED)) dut (
    .Clk(Clk), .Rst(Rst), .seed_load(seed_load), .seed_val(seed_val),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .outEnc(outEnc)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  int stalls = 0;
  logic [77:0] exp_q[$];
  logic [59:0] pt_q[$];
  logic [77:0] last_frame = 78'd0;
  logic [10:0] lfsr_m = SEED;
  logic [5:0]  seq_m = 6'd0;

  // Frames for r=7FF: b = F80_0FFE_0000_07FF, so p=0 gives y=b and p=all-ones gives y=b-2.
  localparam logic [77:0] FRAME_ZERO = {11'h7FF, 61'h0F80_0FFE_0000_07FF, 6'd0};
  localparam logic [77:0] FRAME_ONES = {11'h7FF, 61'h0F80_0FFE_0000_07FD, 6'd1};

  task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [59:0] mask(input logic [10:0] r);
    logic [59:0] b;
    b[10:0]  = r;
    b[21:11] = ~r;
    b[32:22] = ~r;
    b[43:33] = r;
    b[54:44] = ~r;
    b[59:55] = r[4:0];
    return b;
  endfunction

  function automatic logic [77:0] enc(input logic [59:0] p, input logic [10:0] r, input logic [5:0] s);
    logic [60:0] yy;
    yy = {p, 1'b0} + {1'b0, mask(r)};
    return {r, yy, s};
  endfunction

  function automatic logic [59:0] dec(input logic [77:0] f);
    logic [60:0] x;
    x = f[66:6] - {1'b0, mask(f[77:67])};
    return x[60:1];
  endfunction

  // Monitor: pops on every output handshake.
  always @(negedge Clk) begin
    if (!Rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", outEnc, 78'd0);
      end else begin
        logic [77:0] e;
        logic [59:0] p;
        e = exp_q.pop_front();
        p = pt_q.pop_front();
        chk("frame", outEnc, e);
        chk("round_trip", 78'(dec(outEnc)), 78'(p));
      end
      frames++;
      last_frame = outEnc;
    end
  end

  task automatic send(input logic [59:0] d, input bit use_ovr, input logic [77:0] ovr,
                      input bit sl, input logic [10:0] sv);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    seed_load = sl;
    seed_val = sv;
    while (!acc && n < 50) begin
      @(negedge Clk);
      if (in_ready) acc = 1;
      else begin
        stalls++;
        n++;
        @(posedge Clk); #1;
      end
    end
    if (!acc) begin
      chk("accept_timeout", 78'(in_ready), 78'd1);
      in_valid = 1'b0;
      seed_load = 1'b0;
    end else begin
      exp_q.push_back(use_ovr ? ovr : enc(d, lfsr_m, seq_m));
      pt_q.push_back(d);
      @(posedge Clk);
      lfsr_m = sl ? ((sv == 11'd0) ? 11'h001 : sv) : {lfsr_m[9:0], lfsr_m[10] ^ lfsr_m[8]};
      seq_m = seq_m + 6'd1;
      #1;
      in_valid = 1'b0;
      seed_load = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge Clk);
    #1;
    chk("drain_empty", 78'(exp_q.size()), 78'd0);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    in_valid = 1'b0;
    seed_load = 1'b0;
    #1;
    chk("rst_out_valid", 78'(out_valid), 78'd0);
    chk("rst_outEnc", outEnc, 78'd0);
    exp_q.delete();
    pt_q.delete();
    lfsr_m = SEED;
    seq_m = 6'd0;
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    int f0;
    int s0;
    logic [63:0] t;
    #3;
    chk("reset_out_valid", 78'(out_valid), 78'd0);
    chk("reset_outEnc", outEnc, 78'd0);
    chk("reset_in_ready", 78'(in_ready), 78'd1);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk); #1;

    // Vector 1: zero plaintext, rand = SEED, latency of two cycles
    send(60'h0, 1, FRAME_ZERO, 0, 11'd0);
    @(negedge Clk);
    chk("latency_not_yet", 78'(out_valid), 78'd0);
    @(negedge Clk);
    chk("latency_valid", 78'(out_valid), 78'd1);
    @(posedge Clk); #1;

    // Vector 2: all-ones plaintext with rand reloaded to 7FF, carry dropped
    seed_load = 1'b1;
    seed_val = 11'h7FF;
    @(posedge Clk); #1;
    seed_load = 1'b0;
    lfsr_m = 11'h7FF;
    send(60'hFFF_FFFF_FFFF_FFFF, 1, FRAME_ONES, 0, 11'd0);
    drain();

    // Stream of 70 random words with no backpressure
    do_reset();
    f0 = frames;
    s0 = stalls;
    for (int i = 0; i < 70; i++) begin
      t = {$urandom(), $urandom()};
      send(t[59:0], 0, 78'd0, 0, 11'd0);
    end
    drain();
    chk("stream_frames", 78'(frames - f0), 78'd70);
    chk("stream_no_stall", 78'(stalls - s0), 78'd0);
    chk("stream_last_seq", 78'(last_frame[5:0]), 78'd5);

    // Backpressure: two words buffered, third refused, output held
    out_ready = 1'b0;
    send(60'h123_4567_89AB_CDEF, 0, 78'd0, 0, 11'd0);
    send(60'hFED_CBA9_8765_4321, 0, 78'd0, 0, 11'd0);
    in_valid = 1'b1;
    in_data = 60'h0AA_AAAA_5555_5555;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("bp_in_ready_low", 78'(in_ready), 78'd0);
      chk("bp_out_valid", 78'(out_valid), 78'd1);
      chk("bp_outEnc_stable", outEnc, exp_q[0]);
      @(posedge Clk); #1;
    end
    out_ready = 1'b1;
    f0 = frames;
    send(60'h0AA_AAAA_5555_5555, 0, 78'd0, 0, 11'd0);
    drain();
    chk("bp_frames_released", 78'(frames - f0), 78'd3);

    // Seed load with zero in the same cycle as an acceptance
    send(60'h000_0000_0000_0001, 0, 78'd0, 1, 11'h000);
    send(60'h800_0000_0000_0000, 0, 78'd0, 0, 11'd0);
    drain();
    chk("seed_zero_rand", 78'(last_frame[77:67]), 78'h001);

    // Reset with two words in flight
    out_ready = 1'b0;
    send(60'h111_1111_1111_1111, 0, 78'd0, 0, 11'd0);
    send(60'h222_2222_2222_2222, 0, 78'd0, 0, 11'd0);
    @(negedge Clk); #1;
    do_reset();
    out_ready = 1'b1;
    f0 = frames;
    send(60'h0, 1, FRAME_ZERO, 0, 11'd0);
    drain();
    chk("post_rst_frames", 78'(frames - f0), 78'd1);
    chk("post_rst_seq", 78'(last_frame[5:0]), 78'd0);
    chk("post_rst_rand", 78'(last_frame[77:67]), 78'h7FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
